// File: rtl/g11620_sensor_emu.sv
// g11620_sensor_emu
//   Behavioural stand-in for the G11620 line sensor, used for board self-test without the
//   optical head. It watches the controller's integration gate and answers with an AD_SP
//   start pulse, followed by a synthetic line of PIX_NUM+1 pixels in a selectable test pattern.
// Ports
//   clk             : single clock, shared with the controller
//   rst             : asynchronous, active-high reset
//   sensor_reset_in : integration gate from the controller (high = integrating)
//   pattern_sel_in  : 0 ramp, 1 integration level, 2 checker, 3 frame ramp (sampled at gate rise)
//   ad_sp_o         : one-cycle start-of-video pulse
//   pix_data_o      : pixel value, qualified by pix_valid_o
//   pix_valid_o     : high for PIX_NUM+1 consecutive cycles per complete line
//   eos_o           : one-cycle end-of-scan pulse, in the cycle after the last pixel
//   aborted_o       : one-cycle pulse when a new gate rise cuts a line short
//   busy_o          : high whenever the emulator is not idle
//   integ_cnt_o     : gate-high cycles of the most recent accepted integration
//   frame_cnt_o     : count of completed lines
module g11620_sensor_emu #(
   parameter logic [8:0] PIX_NUM   = 9'd511,
   parameter logic [7:0] NOP_CYC   = 8'd14,
   parameter logic [7:0] MIN_INTEG = 8'd2,
   parameter int         DW        = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sensor_reset_in,
   input  logic [1:0]    pattern_sel_in,
   output logic          ad_sp_o,
   output logic [DW-1:0] pix_data_o,
   output logic          pix_valid_o,
   output logic          eos_o,
   output logic          aborted_o,
   output logic          busy_o,
   output logic [31:0]   integ_cnt_o,
   output logic [15:0]   frame_cnt_o
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_INTEG = 3'd1;
   localparam logic [2:0] ST_DELAY = 3'd2;
   localparam logic [2:0] ST_SP    = 3'd3;
   localparam logic [2:0] ST_DATA  = 3'd4;
   localparam logic [2:0] ST_EOS   = 3'd5;

   logic        gate_r;
   logic [2:0]  state_r;
   logic [2:0]  state_s;
   logic [31:0] gcnt_r;
   logic [7:0]  dly_r;
   logic [8:0]  idx_r;
   logic [1:0]  pat_r;
   logic        rise_s;
   logic        fall_s;
   logic        abort_s;

   // Pixel value for a given pattern and index; arithmetic wraps at 2^DW.
   function automatic logic [DW-1:0] pix_val(input logic [1:0]  pat,
                                             input logic [8:0]  idx,
                                             input logic [31:0] integ,
                                             input logic [15:0] frame);
      logic [DW-1:0] idx_w;
      idx_w = DW'(idx);
      case (pat)
         2'd0:    pix_val = idx_w;
         2'd1:    pix_val = (integ > {{(32-DW){1'b0}}, {DW{1'b1}}}) ? {DW{1'b1}} : integ[DW-1:0];
         2'd2:    pix_val = idx[0] ? {DW{1'b1}} : {DW{1'b0}};
         2'd3:    pix_val = frame[DW-1:0] + idx_w;
         default: pix_val = {DW{1'b0}};
      endcase
   endfunction

   assign rise_s  = sensor_reset_in & ~gate_r;
   assign fall_s  = ~sensor_reset_in & gate_r;
   // A fresh gate rise while a line is pending or streaming restarts integration.
   assign abort_s = rise_s & ((state_r == ST_DELAY) | (state_r == ST_SP) | (state_r == ST_DATA));

   // Next-state decode; EOS accepts a gate rise exactly like IDLE.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (rise_s) state_s = ST_INTEG;
            else        state_s = ST_IDLE;
         end
         ST_INTEG: begin
            if (fall_s) state_s = (gcnt_r < {24'd0, MIN_INTEG}) ? ST_IDLE : ST_DELAY;
            else        state_s = ST_INTEG;
         end
         ST_DELAY: begin
            if (rise_s)                state_s = ST_INTEG;
            else if (dly_r == NOP_CYC) state_s = ST_SP;
            else                       state_s = ST_DELAY;
         end
         ST_SP: begin
            if (rise_s) state_s = ST_INTEG;
            else        state_s = ST_DATA;
         end
         ST_DATA: begin
            if (rise_s)                state_s = ST_INTEG;
            else if (idx_r == PIX_NUM) state_s = ST_EOS;
            else                       state_s = ST_DATA;
         end
         ST_EOS: begin
            if (rise_s) state_s = ST_INTEG;
            else        state_s = ST_IDLE;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gate_r      <= 1'b0;
         state_r     <= ST_IDLE;
         gcnt_r      <= 32'd0;
         dly_r       <= 8'd0;
         idx_r       <= 9'd0;
         pat_r       <= 2'd0;
         ad_sp_o     <= 1'b0;
         pix_data_o  <= {DW{1'b0}};
         pix_valid_o <= 1'b0;
         eos_o       <= 1'b0;
         aborted_o   <= 1'b0;
         busy_o      <= 1'b0;
         integ_cnt_o <= 32'd0;
         frame_cnt_o <= 16'd0;
      end else begin
         gate_r      <= sensor_reset_in;
         state_r     <= state_s;
         busy_o      <= (state_s != ST_IDLE);
         aborted_o   <= abort_s;
         ad_sp_o     <= (state_s == ST_SP);
         pix_valid_o <= (state_s == ST_DATA);
         eos_o       <= (state_s == ST_EOS);

         // The rise cycle is itself a gate-high cycle, so the count restarts at 1.
         if ((state_s == ST_INTEG) && (state_r != ST_INTEG)) begin
            gcnt_r <= 32'd1;
            pat_r  <= pattern_sel_in;
         end else if ((state_r == ST_INTEG) && sensor_reset_in && (gcnt_r != 32'hFFFF_FFFF)) begin
            gcnt_r <= gcnt_r + 32'd1;
         end else begin
            gcnt_r <= gcnt_r;
         end

         // The gate-fall cycle counts as delay cycle 0, so DELAY starts at 1.
         if ((state_r == ST_INTEG) && (state_s == ST_DELAY)) begin
            integ_cnt_o <= gcnt_r;
            dly_r       <= 8'd1;
         end else if (state_r == ST_DELAY) begin
            dly_r       <= dly_r + 8'd1;
         end else begin
            dly_r       <= dly_r;
         end

         if ((state_s == ST_DATA) && (state_r == ST_SP)) begin
            idx_r      <= 9'd0;
            pix_data_o <= pix_val(pat_r, 9'd0, integ_cnt_o, frame_cnt_o);
         end else if (state_s == ST_DATA) begin
            idx_r      <= idx_r + 9'd1;
            pix_data_o <= pix_val(pat_r, idx_r + 9'd1, integ_cnt_o, frame_cnt_o);
         end else begin
            idx_r      <= idx_r;
         end

         if (state_s == ST_EOS) begin
            frame_cnt_o <= frame_cnt_o + 16'd1;
         end else begin
            frame_cnt_o <= frame_cnt_o;
         end
      end
   end

endmodule

// File: tb/tb_g11620_sensor_emu.sv
module tb_g11620_sensor_emu;

   localparam int NPIX = 512;
   localparam int NOP  = 14;

   logic        clk;
   logic        rst;
   logic        sensor_reset_in;
   logic [1:0]  pattern_sel_in;
   logic        ad_sp_o;
   logic [15:0] pix_data_o;
   logic        pix_valid_o;
   logic        eos_o;
   logic        aborted_o;
   logic        busy_o;
   logic [31:0] integ_cnt_o;
   logic [15:0] frame_cnt_o;

   typedef struct packed {
      logic [1:0]  kind;   // 0 start pulse, 1 pixel, 2 end of scan, 3 abort
      logic [15:0] val;
   } ev_t;

   ev_t exp_q[$];
   int  n_vec;
   int  n_err;
   bit  done;

   g11620_sensor_emu dut (
      .clk(clk), .rst(rst), .sensor_reset_in(sensor_reset_in), .pattern_sel_in(pattern_sel_in),
      .ad_sp_o(ad_sp_o), .pix_data_o(pix_data_o), .pix_valid_o(pix_valid_o), .eos_o(eos_o),
      .aborted_o(aborted_o), .busy_o(busy_o), .integ_cnt_o(integ_cnt_o), .frame_cnt_o(frame_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, req);
      end
   endtask

   function automatic logic [15:0] model_pix(input int pat, input int i, input int unsigned integ,
                                             input int unsigned frame);
      case (pat)
         0:       return 16'(i);
         1:       return (integ > 32'd65535) ? 16'hFFFF : 16'(integ);
         2:       return (i % 2 == 1) ? 16'hFFFF : 16'h0000;
         default: return 16'(frame + i);
      endcase
   endfunction

   task automatic push_ev(input logic [1:0] kind, input logic [15:0] val);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   // Start pulse, pixels 0..npix-1 and, for a full line, the end-of-scan with the new frame count.
   task automatic push_line(input int pat, input int unsigned integ, input int unsigned frame,
                            input int npix, input bit full);
      push_ev(2'd0, 16'h0000);
      for (int i = 0; i < npix; i++) push_ev(2'd1, model_pix(pat, i, integ, frame));
      if (full) push_ev(2'd2, 16'(frame + 1));
   endtask

   // Called #1 after a rising edge: gate high for exactly hi rising edges.
   task automatic gate(input int hi, input logic [1:0] pat);
      pattern_sel_in  = pat;
      sensor_reset_in = 1'b1;
      repeat (hi) @(posedge clk);
      #1 sensor_reset_in = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int k;
      k = 0;
      do begin
         @(posedge clk);
         #1 k++;
      end while (busy_o && k < 3000);
      check(nm, {31'd0, busy_o}, 32'd0);
   endtask

   task automatic wait_sp(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk);
         #1 cyc++;
      end while (!ad_sp_o && cyc < 100);
      if (!ad_sp_o) check("ad_sp timeout", 32'd0, 32'd1);
   endtask

   task automatic obs(input string nm, input logic [1:0] kind, input logic [15:0] val);
      ev_t e;
      if (exp_q.size() == 0) begin
         check({nm, " unexpected"}, {14'd0, kind, val}, 32'hFFFF_FFFF);
      end else begin
         e = exp_q.pop_front();
         check(nm, {14'd0, kind, val}, {14'd0, e.kind, e.val});
      end
   endtask

   // Monitor: compares every DUT output event against the scoreboard queue.
   initial begin
      forever begin
         @(negedge clk);
         if (done) break;
         if (ad_sp_o)     obs("ad_sp", 2'd0, 16'h0000);
         if (pix_valid_o) obs("pixel", 2'd1, pix_data_o);
         if (eos_o)       obs("eos", 2'd2, frame_cnt_o);
         if (aborted_o)   obs("abort", 2'd3, 16'h0000);
      end
   end

   initial begin
      int lat;
      n_vec = 0;
      n_err = 0;
      done  = 1'b0;
      rst   = 1'b1;
      sensor_reset_in = 1'b0;
      pattern_sel_in  = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset outs", {26'd0, ad_sp_o, pix_valid_o, eos_o, aborted_o, busy_o, |pix_data_o}, 32'd0);
      check("reset integ", integ_cnt_o, 32'd0);
      check("reset frame", {16'd0, frame_cnt_o}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Ramp line, 100-cycle integration, latency from gate fall to start pulse.
      push_line(0, 100, 0, NPIX, 1'b1);
      gate(100, 2'd0);
      wait_sp(lat);
      check("sp latency", lat, NOP + 1);
      check("integ 100", integ_cnt_o, 32'd100);
      wait_idle("idle line1");
      check("frame 1", {16'd0, frame_cnt_o}, 32'd1);

      // Single-cycle glitch: nothing emitted, integration count held.
      gate(1, 2'd0);
      repeat (20) @(posedge clk);
      #1;
      check("glitch busy", {31'd0, busy_o}, 32'd0);
      check("glitch integ", integ_cnt_o, 32'd100);
      check("glitch frame", {16'd0, frame_cnt_o}, 32'd1);

      // Integration-level pattern, below and above the 16-bit limit.
      push_line(1, 40, 1, NPIX, 1'b1);
      gate(40, 2'd1);
      wait_idle("idle p1 40");
      push_line(1, 70000, 2, NPIX, 1'b1);
      gate(70000, 2'd1);
      wait_idle("idle p1 70000");
      check("integ 70000", integ_cnt_o, 32'd70000);

      // Checker pattern, then three frame-ramp lines.
      push_line(2, 30, 3, NPIX, 1'b1);
      gate(30, 2'd2);
      wait_idle("idle p2");
      for (int n = 0; n < 3; n++) begin
         push_line(3, 25, 4 + n, NPIX, 1'b1);
         gate(25, 2'd3);
         wait_idle("idle p3");
      end
      check("frame 7", {16'd0, frame_cnt_o}, 32'd7);

      // Abort at pixel 200 by a new gate rise; the replacement line completes.
      push_line(0, 10, 7, 200, 1'b0);
      push_ev(2'd3, 16'h0000);
      push_line(0, 10, 7, NPIX, 1'b1);
      gate(10, 2'd0);
      wait_sp(lat);
      repeat (200) @(posedge clk);
      #1 gate(10, 2'd0);
      check("abort frame", {16'd0, frame_cnt_o}, 32'd7);
      check("abort integ", integ_cnt_o, 32'd10);

      // Gate rise in the end-of-scan cycle starts the next line straight away.
      lat = 0;
      do begin
         @(posedge clk);
         #1 lat++;
      end while (!eos_o && lat < 2000);
      check("eos seen", {31'd0, eos_o}, 32'd1);
      push_line(2, 5, 8, NPIX, 1'b1);
      gate(5, 2'd2);
      wait_idle("idle eos rise");
      check("frame 9", {16'd0, frame_cnt_o}, 32'd9);
      check("integ 5", integ_cnt_o, 32'd5);

      // Asynchronous reset in mid-line clears outputs immediately.
      push_line(0, 10, 9, 49, 1'b0);
      gate(10, 2'd0);
      wait_sp(lat);
      repeat (50) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("rst outs", {26'd0, ad_sp_o, pix_valid_o, eos_o, aborted_o, busy_o, |pix_data_o}, 32'd0);
      check("rst frame", {16'd0, frame_cnt_o}, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      push_line(0, 20, 0, NPIX, 1'b1);
      gate(20, 2'd0);
      wait_idle("idle final");
      check("frame after rst", {16'd0, frame_cnt_o}, 32'd1);
      repeat (5) @(posedge clk);
      #1;
      check("scoreboard drained", exp_q.size(), 32'd0);
      done = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
